// File: rtl/down_timer_counter.sv
// down_timer_counter: loadable down-counter/timer with a one-cycle terminal-count pulse and
// optional auto-reload. A load starts a run; each enabled cycle in RUN decrements q, and on
// the q == 1 event the counter either reloads (reload=1) or drops to 0 and goes idle.
// Optional feature: define DOWN_TIMER_PRESCALE_EN to divide en by PRESCALE before it
// decrements the count. Without the macro, every en cycle in RUN is a decrement.
// clear is an asynchronous active-high reset.
module down_timer_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  // Reject configurations the terminal-at-one scheme and the prescaler cannot support.
  if (WIDTH < 2) begin : gen_bad_width
    $error("down_timer_counter: WIDTH must be >= 2");
  end
  if (PRESCALE < 2) begin : gen_bad_prescale
    $error("down_timer_counter: PRESCALE must be >= 2");
  end

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] reload_val_q;
  // High on cycles where a decrement or terminal event may happen (before the state check).
  logic             tick;

`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PsW-1:0] ps_q;
  logic           ps_wrap;

  assign ps_wrap = (ps_q == PsW'(PRESCALE - 1));
  assign tick    = en && ps_wrap;

  // Prescaler: counts en cycles in RUN, wrapping on every PRESCALE-th one. It never advances
  // in IDLE, and the only RUN->IDLE transitions happen on a load or a wrap, so it is already
  // zero whenever the FSM is idle.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      ps_q <= '0;
    end else if (load) begin
      ps_q <= '0;
    end else if ((state_q == StRun) && en) begin
      if (ps_wrap) begin
        ps_q <= '0;
      end else begin
        ps_q <= ps_q + 1'b1;
      end
    end
  end
`else
  assign tick = en;
`endif

  // Main FSM with registered q/tc/busy. Priority: clear > load > count.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q      <= StIdle;
      q            <= '0;
      tc           <= 1'b0;
      busy         <= 1'b0;
      reload_val_q <= '0;
    end else if (load) begin
      // A load always wins, including on what would have been the terminal cycle.
      reload_val_q <= load_val;
      q            <= load_val;
      tc           <= 1'b0;
      if (load_val != '0) begin
        state_q <= StRun;
        busy    <= 1'b1;
      end else begin
        state_q <= StIdle;
        busy    <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
      if ((state_q == StRun) && tick) begin
        if (q == WIDTH'(1)) begin
          // Terminal event: handled at one so q never wraps below zero.
          tc <= 1'b1;
          if (reload) begin
            q <= reload_val_q;
          end else begin
            q       <= '0;
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end else begin
          q <= q - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_down_timer_counter.sv
// Testbench for down_timer_counter: an integer-level timer model checked against the DUT on
// every falling edge, plus directed sequences with hand-computed literal expectations.
module tb_down_timer_counter;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned PRESCALE = 4;

  logic             clk;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             reload;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  int errors = 0;
  int checks = 0;

  down_timer_counter #(
    .WIDTH   (WIDTH),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk     (clk),
    .clear   (clear),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .reload  (reload),
    .q       (q),
    .tc      (tc),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: remaining count, saved period, running flag, pulse flag, en count toward a step.
  int m_q   = 0;
  int m_rel = 0;
  int m_ps  = 0;
  bit m_run = 1'b0;
  bit m_tc  = 1'b0;
  bit m_step;

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      m_q = 0; m_rel = 0; m_ps = 0; m_run = 1'b0; m_tc = 1'b0;
    end else if (load) begin
      m_rel = int'(load_val);
      m_q   = int'(load_val);
      m_run = (load_val != 0);
      m_tc  = 1'b0;
      m_ps  = 0;
    end else begin
      m_step = m_run && en;
`ifdef DOWN_TIMER_PRESCALE_EN
      if (m_run && en) begin
        m_ps++;
        m_step = (m_ps == PRESCALE);
        if (m_step) m_ps = 0;
      end
`endif
      m_tc = 1'b0;
      if (m_step) begin
        if (m_q == 1) begin
          m_tc = 1'b1;
          if (reload) m_q = m_rel;
          else begin
            m_q   = 0;
            m_run = 1'b0;
          end
        end else begin
          m_q = m_q - 1;
        end
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model q", int'(q), m_q);
    chk("model tc", int'(tc), int'(m_tc));
    chk("model busy", int'(busy), int'(m_run));
  end

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input int eq, input int etc, input int ebusy);
    chk({name, " q"}, int'(q), eq);
    chk({name, " tc"}, int'(tc), etc);
    chk({name, " busy"}, int'(busy), ebusy);
  endtask

  int exp_q3[6]  = '{2, 1, 3, 2, 1, 3};
  int exp_tc3[6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    clear = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; reload = 1'b0;

    // Reset, then en must not move an idle counter.
    cyc(); cyc();
    clear = 1'b0;
    expect_out("reset", 0, 0, 0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_out("idle en", 0, 0, 0);
    end

`ifndef DOWN_TIMER_PRESCALE_EN
    // One-shot from 5.
    load = 1'b1; load_val = 4'd5; reload = 1'b0;
    cyc();
    load = 1'b0;
    expect_out("oneshot load", 5, 0, 1);
    for (int k = 4; k >= 1; k--) begin
      cyc();
      expect_out("oneshot dec", k, 0, 1);
    end
    cyc();
    expect_out("oneshot term", 0, 1, 0);
    cyc();
    expect_out("oneshot after", 0, 0, 0);

    // Auto-reload with period 3.
    load = 1'b1; load_val = 4'd3; reload = 1'b1;
    cyc();
    load = 1'b0;
    expect_out("reload load", 3, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      expect_out("reload seq", exp_q3[i], exp_tc3[i], 1);
    end
    en = 1'b0; reload = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    expect_out("clear after reload", 0, 0, 0);

    // Gated enable, then reload mid-count.
    load = 1'b1; load_val = 4'd6;
    cyc();
    load = 1'b0;
    expect_out("gate load", 6, 0, 1);
    en = 1'b1; cyc(); expect_out("gate en1", 5, 0, 1);
    en = 1'b0; cyc(); expect_out("gate en0", 5, 0, 1);
    en = 1'b1; cyc(); expect_out("gate en1b", 4, 0, 1);
    en = 1'b0; cyc(); expect_out("gate en0b", 4, 0, 1);
    load = 1'b1; load_val = 4'd9;
    cyc();
    load = 1'b0; en = 1'b1;
    expect_out("gate reload9", 9, 0, 1);
    cyc();
    expect_out("gate restart", 8, 0, 1);

    // Load of zero stays idle with no pulse.
    load = 1'b1; load_val = 4'd0;
    cyc();
    load = 1'b0;
    expect_out("load zero", 0, 0, 0);
    cyc();
    expect_out("load zero en", 0, 0, 0);

    // Asynchronous clear between edges at q=7.
    load = 1'b1; load_val = 4'd9;
    cyc();
    load = 1'b0;
    cyc(); cyc();
    expect_out("pre clear", 7, 0, 1);
    #1 clear = 1'b1;
    #1 expect_out("async clear", 0, 0, 0);
    clear = 1'b0;
    cyc();
    expect_out("post clear", 0, 0, 0);

    // Load on the terminal cycle wins and suppresses tc.
    load = 1'b1; load_val = 4'd2;
    cyc();
    load = 1'b0;
    cyc();
    expect_out("term load pre", 1, 0, 1);
    load = 1'b1; load_val = 4'd4;
    cyc();
    load = 1'b0;
    expect_out("term load", 4, 0, 1);

    // Reload value 1: tc high every cycle.
    load = 1'b1; load_val = 4'd1; reload = 1'b1;
    cyc();
    load = 1'b0;
    expect_out("rel1 load", 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_out("rel1 tc", 1, 1, 1);
    end
    reload = 1'b0;
    cyc();
    expect_out("rel1 stop", 0, 1, 0);
`else
    // Prescaled: load 2, each value held for PRESCALE enables.
    load = 1'b1; load_val = 4'd2; reload = 1'b0;
    cyc();
    load = 1'b0;
    expect_out("ps load", 2, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_out("ps hold2", 2, 0, 1);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      expect_out("ps hold1", 1, 0, 1);
    end
    cyc();
    expect_out("ps term", 0, 1, 0);
    cyc();
    expect_out("ps after", 0, 0, 0);
`endif

    en = 1'b0;
    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
